// File: rtl/pgm_frame_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : pgm_frame_writer_if
// Description : Pixel-in / word-out handshake bundle for the PGM frame writer.
//               master : the frame writer itself (drives words, pix_ready)
//               slave  : the pixel source and word sink around it
// Revision    : 1.0 - initial release
// ============================================================================
interface pgm_frame_writer_if;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_eol;
  logic        out_last;

  modport master (
    input  pix_data, pix_valid, out_ready,
    output pix_ready, out_data, out_valid, out_eol, out_last
  );

  modport slave (
    output pix_data, pix_valid, out_ready,
    input  pix_ready, out_data, out_valid, out_eol, out_last
  );
endinterface
`default_nettype wire

// File: rtl/pgm_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : pgm_frame_writer
// Description : Frames a raster 8-bit pixel stream as a PGM word stream:
//               header words (width, height, maxval), then pixels packed four
//               per 32-bit word, MSB-first.
//               Optional macro PGM_WRITER_CHECKSUM_EN appends a trailer word
//               holding the 32-bit sum of all pixels of the frame.
// Revision    : 1.0 - initial release
// ============================================================================
module pgm_frame_writer #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 320,
  parameter int MAXVAL = 255
) (
  input  wire logic            clock,
  input  wire logic            reset,
  input  wire logic            start,
  pgm_frame_writer_if.master   bus,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int c_COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int c_ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_HDR_W   = 3'd1;
  localparam logic [2:0] c_HDR_H   = 3'd2;
  localparam logic [2:0] c_HDR_MAX = 3'd3;
  localparam logic [2:0] c_PIXELS  = 3'd4;
  localparam logic [2:0] c_DONE    = 3'd5;
`ifdef PGM_WRITER_CHECKSUM_EN
  localparam logic [2:0] c_TRAILER = 3'd6;
`endif

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [c_COL_W-1:0] r_col;
  logic [c_ROW_W-1:0] r_row;
  logic [1:0]         r_byte_cnt;
  logic [23:0]        r_pack;       // up to three earlier bytes of the word
  logic               r_pix_done;   // final pixel of the frame accepted
  logic [31:0]        r_out_data;
  logic               r_out_valid;
  logic               r_out_eol;
  logic               r_out_last;
  logic               r_frame_done;
`ifdef PGM_WRITER_CHECKSUM_EN
  logic [31:0]        r_sum;
`endif

  logic w_pix_ready;
  logic w_busy;
  logic w_pix_acc;
  logic w_out_hs;
  logic w_col_last;
  logic w_row_last;

  assign w_pix_acc  = w_pix_ready && bus.pix_valid;
  assign w_out_hs   = r_out_valid && bus.out_ready;
  assign w_col_last = (r_col == c_COL_W'(WIDTH - 1));
  assign w_row_last = (r_row == c_ROW_W'(HEIGHT - 1));

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic: every non-idle step waits for a word handshake
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:    if (start)    w_state_nxt = c_HDR_W;
      c_HDR_W:   if (w_out_hs) w_state_nxt = c_HDR_H;
      c_HDR_H:   if (w_out_hs) w_state_nxt = c_HDR_MAX;
      c_HDR_MAX: if (w_out_hs) w_state_nxt = c_PIXELS;
`ifdef PGM_WRITER_CHECKSUM_EN
      c_PIXELS:  if (w_out_hs && r_pix_done) w_state_nxt = c_TRAILER;
      c_TRAILER: if (w_out_hs) w_state_nxt = c_DONE;
`else
      c_PIXELS:  if (w_out_hs && r_pix_done) w_state_nxt = c_DONE;
`endif
      c_DONE:    w_state_nxt = c_IDLE;
      default:   w_state_nxt = c_IDLE;
    endcase
  end

  // FSM outputs: pixel back-pressure only blocks the byte that would complete
  // a word while the previous word is still unaccepted
  always_comb begin
    w_busy      = (r_state != c_IDLE);
    w_pix_ready = 1'b0;
    if (r_state == c_PIXELS && !r_pix_done)
      w_pix_ready = (r_byte_cnt != 2'd3) || !r_out_valid || bus.out_ready;
  end

  // Word datapath: header load, pixel packing, raster counters, word retire
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out_data   <= 32'd0;
      r_out_valid  <= 1'b0;
      r_out_eol    <= 1'b0;
      r_out_last   <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_byte_cnt   <= 2'd0;
      r_pack       <= 24'd0;
      r_pix_done   <= 1'b0;
      r_frame_done <= 1'b0;
`ifdef PGM_WRITER_CHECKSUM_EN
      r_sum        <= 32'd0;
`endif
    end else begin
      r_frame_done <= (r_state == c_DONE);
      if (r_state == c_IDLE && start) begin
        r_out_data  <= 32'(WIDTH);
        r_out_valid <= 1'b1;
        r_out_eol   <= 1'b0;
        r_out_last  <= 1'b0;
        r_col       <= '0;
        r_row       <= '0;
        r_byte_cnt  <= 2'd0;
        r_pack      <= 24'd0;
        r_pix_done  <= 1'b0;
`ifdef PGM_WRITER_CHECKSUM_EN
        r_sum       <= 32'd0;
`endif
      end else if (r_state == c_HDR_W && w_out_hs) begin
        r_out_data <= 32'(HEIGHT);
      end else if (r_state == c_HDR_H && w_out_hs) begin
        r_out_data <= 32'(MAXVAL);
      end else if (w_pix_acc) begin
        r_pack     <= {r_pack[15:0], bus.pix_data};
        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef PGM_WRITER_CHECKSUM_EN
        r_sum      <= r_sum + 32'(bus.pix_data);
`endif
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (r_byte_cnt == 2'd3) begin
          r_out_data  <= {r_pack, bus.pix_data};
          r_out_valid <= 1'b1;
          r_out_eol   <= w_col_last;
`ifdef PGM_WRITER_CHECKSUM_EN
          r_out_last  <= 1'b0;
`else
          r_out_last  <= w_col_last && w_row_last;
`endif
          if (w_col_last && w_row_last) r_pix_done <= 1'b1;
        end else if (w_out_hs) begin
          r_out_valid <= 1'b0;
          r_out_eol   <= 1'b0;
          r_out_last  <= 1'b0;
        end
      end else if (w_out_hs) begin
`ifdef PGM_WRITER_CHECKSUM_EN
        if (r_state == c_PIXELS && r_pix_done) begin
          r_out_data  <= r_sum;
          r_out_valid <= 1'b1;
          r_out_eol   <= 1'b0;
          r_out_last  <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
          r_out_eol   <= 1'b0;
          r_out_last  <= 1'b0;
        end
`else
        r_out_valid <= 1'b0;
        r_out_eol   <= 1'b0;
        r_out_last  <= 1'b0;
`endif
      end
    end
  end

  assign bus.pix_ready = w_pix_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign bus.out_eol   = r_out_eol;
  assign bus.out_last  = r_out_last;
  assign busy          = w_busy;
  assign frame_done    = r_frame_done;

endmodule
`default_nettype wire
